clock_divider: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 12 +
 rtl/clock_divider_cnt.sv | 31 +++
 rtl/clock_divider.sv | 60 ++++++
 tb/tb_clock_divider.sv | 126 ++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the board-clock divider.
package clock_divider_pkg;

  localparam int unsigned CLK_IN_HZ       = 50_000_000;
  localparam int unsigned DEFAULT_DIVISOR = 100_000;

  // Input cycles per output period for a target output frequency in Hz.
  function automatic int unsigned calc_divisor(input int unsigned f_out);
    return CLK_IN_HZ / f_out;
  endfunction

endpackage

// File: rtl/clock_divider_cnt.sv
// Modulo-N up counter with async active-low clear and terminal-count flag.
module clock_divider_cnt
  import clock_divider_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  // Explicit compare so non-power-of-two N wraps correctly.
  assign w_tc = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (w_tc) r_cnt <= '0;
    else           r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: low for ceil(N/2) input cycles, high for floor(N/2).
// Define CLOCK_DIVIDER_ODD_DUTY_EN for exact 50% duty on odd DIVISOR.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
  parameter int unsigned CNT_W   = $clog2(DIVISOR)
) (
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned      H       = (DIVISOR + 1) / 2;
  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(H - 1);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be at least 2");
  end

  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             r_pos;

  clock_divider_cnt #(
    .N (DIVISOR),
    .W (CNT_W)
  ) u_cnt (
    .i_clk   (in),
    .i_rst_n (rst),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // Decode the post-edge count from the pre-edge one: out is high once
  // the count reaches H, and drops when the counter wraps.
  always_ff @(posedge in or negedge rst) begin
    if (!rst) r_pos <= 1'b0;
    else      r_pos <= (w_cnt >= RISE_AT) && !w_tc;
  end

`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
  if (DIVISOR % 2 == 1) begin : g_odd_duty
    logic r_neg;

    // Half-cycle-delayed copy stretches the high phase by half an input period.
    always_ff @(negedge in or negedge rst) begin
      if (!rst) r_neg <= 1'b0;
      else      r_neg <= r_pos;
    end

    assign out = r_pos | r_neg;
  end else begin : g_even_duty
    assign out = r_pos;
  end
`else
  assign out = r_pos;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider across several DIVISOR values.
module tb_clock_divider;
  import clock_divider_pkg::*;

  logic clk = 1'b1;
  logic rst_a, rst_b, rst_c;
  logic o4, o2, o5, o4b, o100k;

  int ntests = 0;
  int nfail  = 0;
  int ecnt   = 0;
  int ntr    = 0;
  int guard;

  // Rising edges at 20, 40, 60 ... ns.
  initial forever #10 clk = ~clk;

  clock_divider #(.DIVISOR(4))       u4    (.rst(rst_a), .in(clk), .out(o4));
  clock_divider #(.DIVISOR(2))       u2    (.rst(rst_a), .in(clk), .out(o2));
  clock_divider #(.DIVISOR(5))       u5    (.rst(rst_a), .in(clk), .out(o5));
  clock_divider #(.DIVISOR(4))       u4b   (.rst(rst_b), .in(clk), .out(o4b));
  clock_divider #(.DIVISOR(100_000)) u100k (.rst(rst_c), .in(clk), .out(o100k));

  always @(posedge clk) if (rst_c === 1'b1) ecnt++;
  always @(o100k) if (rst_c === 1'b1) ntr++;

  task automatic chk(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Post-edge levels for rising edges 1..10 after release.
  logic e4 [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  logic e2 [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic e5n[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
  logic e5p[10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
`else
  logic e5p[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
`endif

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    chk_int("calc_divisor_500hz", int'(calc_divisor(500)), 100_000);

    #5;
    chk("rst_o4", o4, 1'b0);
    chk("rst_o2", o2, 1'b0);
    chk("rst_o5", o5, 1'b0);
    chk("rst_o4b", o4b, 1'b0);
    chk("rst_o100k", o100k, 1'b0);

    #45;  // t = 50, between edges
    rst_a = 1'b1;
    rst_c = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("d4_edge%0d", i + 1), o4, e4[i]);
      chk($sformatf("d2_edge%0d", i + 1), o2, e2[i]);
      chk($sformatf("d5_edge%0d", i + 1), o5, e5p[i]);
      @(negedge clk); #1;
      chk($sformatf("d4_neg%0d", i + 1), o4, e4[i]);
      chk($sformatf("d5_neg%0d", i + 1), o5, e5n[i]);
    end

    // Mid-high-phase reset on the DIVISOR=4 instance (t = 254, no edge).
    #3;
    rst_a = 1'b0;
    #1;
    chk("midrst_o4", o4, 1'b0);
    chk("midrst_o5", o5, 1'b0);
    #15;  // t = 270
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("rel_o4_e1", o4, 1'b0);
    chk("rel_o2_e1", o2, 1'b1);
    @(posedge clk); #1;
    chk("rel_o4_e2", o4, 1'b1);

    // Release coincident with a rising edge; the edge samples reset still low.
    @(posedge clk);
    rst_b <= 1'b1;
    #1;
    chk("coinc_e0", o4b, 1'b0);
    @(posedge clk); #1;
    chk("coinc_e1", o4b, 1'b0);
    @(posedge clk); #1;
    chk("coinc_e2", o4b, 1'b1);
    @(posedge clk); #1;
    chk("coinc_e3", o4b, 1'b1);
    @(posedge clk); #1;
    chk("coinc_e4", o4b, 1'b0);

    // DIVISOR=100_000: first rise exactly at edge 50_000 (1 ms), no earlier toggles.
    guard = 0;
    while (ecnt < 49_999 && guard < 60_000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk_int("d100k_reach_49999", ecnt, 49_999);
    chk("d100k_low_49999", o100k, 1'b0);
    chk_int("d100k_no_glitch", ntr, 0);
    @(posedge clk); #1;
    chk("d100k_rise_50000", o100k, 1'b1);
    chk_int("d100k_one_transition", ntr, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
